ag_ps2_keyb: RTL and testbench

//  PS/2 keyboard front end for the Agat-7 core. Receives PS/2 frames from the
//  pre-filtered ps2 bus (signal_filter outputs) and decodes make/break/extended

---
 rtl/ag_ps2_keyb_pkg.sv | 29 ++
 rtl/ag_ps2_keyb_if.sv | 25 ++
 rtl/ag_ps2_keyb_keymap.sv | 83 ++++++++
 rtl/ag_ps2_keyb.sv | 200 ++++++++++++++++++++
 tb/tb_ag_ps2_keyb.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ag_ps2_keyb_pkg.sv
// Shared definitions for the PS/2 keyboard front end: scan codes and RX states.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package ag_ps2_keyb_pkg;

   // PS/2 set-2 scan codes with special meaning to the decoder
   localparam logic [7:0] SC_E0     = 8'hE0;
   localparam logic [7:0] SC_F0     = 8'hF0;
   localparam logic [7:0] SC_E1     = 8'hE1;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_F12    = 8'h07;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_SCROLL = 8'h7E;

   // Receiver frame states: start bit is consumed in IDLE
   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_t;

   // True when data byte plus parity bit carry an odd number of ones
   function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
      return ^{dat, par};
   endfunction

endpackage

// File: rtl/ag_ps2_keyb_if.sv
// Signal bundle between the PS/2 front end and the rest of the Agat core.
// Latency: n/a (wires only).
// Backpressure: none; key latch is level-held until the CPU clears the strobe.
interface ag_ps2_keyb_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       key_clear;
   logic [7:0] key_reg;
   logic       key_rus;
   logic       key_rst;
   logic       key_pause;
   logic       frame_err;

   // Host side: drives the PS/2 lines and the CPU clear, reads the latch
   modport master (
      output ps2_clk, ps2_data, key_clear,
      input  key_reg, key_rus, key_rst, key_pause, frame_err
   );

   // Keyboard front end side
   modport slave (
      input  ps2_clk, ps2_data, key_clear,
      output key_reg, key_rus, key_rst, key_pause, frame_err
   );
endinterface

// File: rtl/ag_ps2_keyb_keymap.sv
// Scan code to 7-bit Agat key code lookup (0 = key not mapped).
// Latency: combinational.
// Backpressure: none.
module ag_ps2_keyb_keymap (
   input  logic       ext_i,
   input  logic       shift_i,
   input  logic       rus_i,
   input  logic [7:0] scan_i,
   output logic [6:0] code_o
);

   logic       let_hit;
   logic [4:0] let_idx;
   logic       dig_hit;
   logic [3:0] dig_val;

   // Letter keys: alphabetical index A=0 .. Z=25
   always_comb begin
      let_hit = 1'b1;
      let_idx = 5'd0;
      case (scan_i)
         8'h1C: let_idx = 5'd0;   8'h32: let_idx = 5'd1;   8'h21: let_idx = 5'd2;
         8'h23: let_idx = 5'd3;   8'h24: let_idx = 5'd4;   8'h2B: let_idx = 5'd5;
         8'h34: let_idx = 5'd6;   8'h33: let_idx = 5'd7;   8'h43: let_idx = 5'd8;
         8'h3B: let_idx = 5'd9;   8'h42: let_idx = 5'd10;  8'h4B: let_idx = 5'd11;
         8'h3A: let_idx = 5'd12;  8'h31: let_idx = 5'd13;  8'h44: let_idx = 5'd14;
         8'h4D: let_idx = 5'd15;  8'h15: let_idx = 5'd16;  8'h2D: let_idx = 5'd17;
         8'h1B: let_idx = 5'd18;  8'h2C: let_idx = 5'd19;  8'h3C: let_idx = 5'd20;
         8'h2A: let_idx = 5'd21;  8'h1D: let_idx = 5'd22;  8'h22: let_idx = 5'd23;
         8'h35: let_idx = 5'd24;  8'h1A: let_idx = 5'd25;
         default: let_hit = 1'b0;
      endcase
   end

   // Top-row digit keys
   always_comb begin
      dig_hit = 1'b1;
      dig_val = 4'd0;
      case (scan_i)
         8'h45: dig_val = 4'd0;  8'h16: dig_val = 4'd1;  8'h1E: dig_val = 4'd2;
         8'h26: dig_val = 4'd3;  8'h25: dig_val = 4'd4;  8'h2E: dig_val = 4'd5;
         8'h36: dig_val = 4'd6;  8'h3D: dig_val = 4'd7;  8'h3E: dig_val = 4'd8;
         8'h46: dig_val = 4'd9;
         default: dig_hit = 1'b0;
      endcase
   end

   // Final code: extended keys are cursor keys; Cyrillic letters live at 60h+
   always_comb begin
      code_o = 7'd0;
      if (ext_i) begin
         case (scan_i)
            8'h75:   code_o = 7'h19;   // up
            8'h72:   code_o = 7'h1A;   // down
            8'h6B:   code_o = 7'h08;   // left
            8'h74:   code_o = 7'h15;   // right
            default: code_o = 7'd0;
         endcase
      end else if (let_hit) begin
         if (rus_i)
            code_o = 7'h60 + {2'b00, let_idx};
         else if (shift_i)
            code_o = 7'h61 + {2'b00, let_idx};
         else
            code_o = 7'h41 + {2'b00, let_idx};
      end else if (dig_hit) begin
         // shifted 1..9 give the punctuation row 21h..29h; shifted 0 stays '0'
         if (shift_i && (dig_val != 4'd0))
            code_o = 7'h20 + {3'b000, dig_val};
         else
            code_o = 7'h30 + {3'b000, dig_val};
      end else begin
         case (scan_i)
            8'h29:   code_o = 7'h20;   // space
            8'h5A:   code_o = 7'h0D;   // enter
            8'h76:   code_o = 7'h1B;   // escape
            8'h66:   code_o = 7'h08;   // backspace
            default: code_o = 7'd0;
         endcase
      end
   end

endmodule

// File: rtl/ag_ps2_keyb.sv
// PS/2 keyboard receiver and decoder producing the Agat key latch and control flags.
// Latency: key_reg updates 2 clk after the synchronised STOP-bit fall.
// Backpressure: none; a new key overwrites an unread latch (strobe stays set).
module ag_ps2_keyb
   import ag_ps2_keyb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 2000,
   parameter int SYNC_STAGES = 2
) (
   input logic           clk,
   input logic           rst_n,
   ag_ps2_keyb_if.slave  kb
);

   localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] dat_sync_q;
   logic                   clk_prev_q;
   logic                   ps2c_s;
   logic                   ps2d_s;
   logic                   fall;

   rx_state_t     state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          byte_vld_q, byte_vld_d;
   logic          ferr_q, ferr_d;

   logic       brk_q, brk_d;
   logic       ext_q, ext_d;
   logic       shift_q, shift_d;
   logic       rus_q, rus_d;
   logic       rst_q, rst_d;
   logic       pause_q, pause_d;
   logic [7:0] key_q, key_d;
   logic [6:0] map_code;

   assign ps2c_s = clk_sync_q[SYNC_STAGES-1];
   assign ps2d_s = dat_sync_q[SYNC_STAGES-1];
   assign fall   = clk_prev_q & ~ps2c_s;

   // Synchronise the PS/2 lines; idle-high reset value avoids a false fall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         clk_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], kb.ps2_clk};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], kb.ps2_data};
         clk_prev_q <= ps2c_s;
      end
   end

   // Receiver state and frame registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RX_IDLE;
         bitcnt_q   <= 3'd0;
         shreg_q    <= 8'd0;
         par_q      <= 1'b0;
         tmo_q      <= '0;
         byte_vld_q <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         tmo_q      <= tmo_d;
         byte_vld_q <= byte_vld_d;
         ferr_q     <= ferr_d;
      end
   end

   // Frame sequencing, stop/parity check and mid-frame inactivity abort
   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      tmo_d      = '0;
      byte_vld_d = 1'b0;
      ferr_d     = 1'b0;
      if ((state_q != RX_IDLE) && !fall)
         tmo_d = tmo_q + 1'b1;
      case (state_q)
         RX_IDLE: begin
            if (fall && !ps2d_s) begin
               state_d  = RX_DATA;
               bitcnt_d = 3'd0;
            end
         end
         RX_DATA: begin
            if (fall) begin
               shreg_d  = {ps2d_s, shreg_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7)
                  state_d = RX_PARITY;
            end
         end
         RX_PARITY: begin
            if (fall) begin
               par_d   = ps2d_s;
               state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (fall) begin
               state_d = RX_IDLE;
               if (ps2d_s && odd_parity_ok(shreg_q, par_q))
                  byte_vld_d = 1'b1;
               else
                  ferr_d = 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
      // PS/2 clock stalled mid-frame: drop the partial byte
      if ((state_q != RX_IDLE) && !fall && (tmo_q == TMO_LAST)) begin
         state_d = RX_IDLE;
         tmo_d   = '0;
         ferr_d  = 1'b1;
      end
   end

   ag_ps2_keyb_keymap u_keymap (
      .ext_i   (ext_q),
      .shift_i (shift_q),
      .rus_i   (rus_q),
      .scan_i  (shreg_q),
      .code_o  (map_code)
   );

   // Decoder state, key latch and user-visible flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brk_q   <= 1'b0;
         ext_q   <= 1'b0;
         shift_q <= 1'b0;
         rus_q   <= 1'b0;
         rst_q   <= 1'b0;
         pause_q <= 1'b0;
         key_q   <= 8'h00;
      end else begin
         brk_q   <= brk_d;
         ext_q   <= ext_d;
         shift_q <= shift_d;
         rus_q   <= rus_d;
         rst_q   <= rst_d;
         pause_q <= pause_d;
         key_q   <= key_d;
      end
   end

   // Prefix tracking and key event handling; a fresh latch beats the CPU clear
   always_comb begin
      brk_d   = brk_q;
      ext_d   = ext_q;
      shift_d = shift_q;
      rus_d   = rus_q;
      rst_d   = rst_q;
      pause_d = pause_q;
      key_d   = key_q;
      if (kb.key_clear)
         key_d[7] = 1'b0;
      if (byte_vld_q) begin
         case (shreg_q)
            SC_E0: ext_d = 1'b1;
            SC_F0: brk_d = 1'b1;
            SC_E1: ;
            default: begin
               brk_d = 1'b0;
               ext_d = 1'b0;
               case (shreg_q)
                  SC_LSHIFT, SC_RSHIFT: shift_d = !brk_q;
                  SC_F12:               rst_d   = !brk_q;
                  SC_CAPS:   if (!brk_q) rus_d   = !rus_q;
                  SC_SCROLL: if (!brk_q) pause_d = !pause_q;
                  default: begin
                     if (!brk_q && (map_code != 7'd0))
                        key_d = {1'b1, map_code};
                  end
               endcase
            end
         endcase
      end
   end

   assign kb.key_reg   = key_q;
   assign kb.key_rus   = rus_q;
   assign kb.key_rst   = rst_q;
   assign kb.key_pause = pause_q;
   assign kb.frame_err = ferr_q;

endmodule

// File: tb/tb_ag_ps2_keyb.sv
// Bench for the PS/2 keyboard front end: vector table, corner sequences, random keys.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_ag_ps2_keyb;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #500 clk = ~clk;   // 1 MHz phi_2

   ag_ps2_keyb_if kif ();

   ag_ps2_keyb #(.TIMEOUT_CYC(2000), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kb    (kif.slave)
   );

   int total    = 0;
   int bad      = 0;
   int err_seen = 0;

   // Count frame error pulses away from the active edge
   always @(negedge clk) if (rst_n && (kif.frame_err === 1'b1)) err_seen++;

   initial begin
      #98_000_000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          clr;
      int          n;
      logic [23:0] bytes;     // first byte in [7:0]
      logic [7:0]  exp_reg;
      logic        exp_rus;
      logic        exp_rst;
      logic        exp_pause;
   } vec_t;

   vec_t vt [23];

   logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                  8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                  8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                  8'h35, 8'h1A};
   logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46};
   logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h1E, 8'h45, 8'h29, 8'h5A,
                             8'h66, 8'h12, 8'h59, 8'h58, 8'h7E, 8'h07, 8'hE0, 8'hF0,
                             8'hF0, 8'h75, 8'h6B, 8'h05};

   // Reference keyboard state
   bit         m_brk, m_ext, m_shift, m_rus, m_rst, m_pause;
   logic [7:0] m_latch;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One PS/2 bit at 12.5 kHz: data set while clock high, 40 us low phase
   task automatic ps2_bit(input logic b);
      kif.ps2_data = b;
      wait_cyc(20);
      kif.ps2_clk = 1'b0;
      wait_cyc(40);
      kif.ps2_clk = 1'b1;
      wait_cyc(20);
   endtask

   // Full frame; optionally corrupt parity, or pulse key_clear on the latch cycle
   task automatic send_byte(input logic [7:0] d, input bit bad_par, input bit clr_latch,
                            input logic [7:0] pre_exp, input logic [7:0] new_exp);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit((~^d) ^ bad_par);
      if (!clr_latch) begin
         ps2_bit(1'b1);
      end else begin
         kif.ps2_data = 1'b1;
         wait_cyc(20);
         kif.ps2_clk = 1'b0;
         wait_cyc(3);
         check("latch_not_early", kif.key_reg, pre_exp);
         kif.key_clear = 1'b1;
         wait_cyc(1);
         kif.key_clear = 1'b0;
         check("clear_on_latch", kif.key_reg, new_exp);
         wait_cyc(36);
         kif.ps2_clk = 1'b1;
         wait_cyc(20);
      end
   endtask

   task automatic pulse_clear();
      kif.key_clear = 1'b1;
      wait_cyc(1);
      kif.key_clear = 1'b0;
      wait_cyc(2);
   endtask

   function automatic logic [6:0] ref_code(input logic [7:0] sc, input bit ext,
                                           input bit sh, input bit rus);
      if (ext) begin
         if (sc == 8'h75) return 7'h19;
         if (sc == 8'h72) return 7'h1A;
         if (sc == 8'h6B) return 7'h08;
         if (sc == 8'h74) return 7'h15;
         return 7'h00;
      end
      for (int i = 0; i < 26; i++)
         if (letter_sc[i] == sc)
            return rus ? 7'(8'h60 + i) : (sh ? 7'(8'h61 + i) : 7'(8'h41 + i));
      for (int i = 0; i < 10; i++)
         if (digit_sc[i] == sc)
            return (sh && i != 0) ? 7'(8'h20 + i) : 7'(8'h30 + i);
      if (sc == 8'h29) return 7'h20;
      if (sc == 8'h5A) return 7'h0D;
      if (sc == 8'h76) return 7'h1B;
      if (sc == 8'h66) return 7'h08;
      return 7'h00;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      logic [6:0] c;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE1) begin end
      else begin
         if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
         else if (b == 8'h07) m_rst = !m_brk;
         else if (b == 8'h58) begin if (!m_brk) m_rus = !m_rus; end
         else if (b == 8'h7E) begin if (!m_brk) m_pause = !m_pause; end
         else if (!m_brk) begin
            c = ref_code(b, m_ext, m_shift, m_rus);
            if (c != 7'h00) m_latch = {1'b1, c};
         end
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   initial begin
      int err0;
      int waited;
      logic [7:0] b;

      vt[0]  = '{0, 1, 24'h00001C, 8'hC1, 0, 0, 0};
      vt[1]  = '{1, 0, 24'h000000, 8'h41, 0, 0, 0};
      vt[2]  = '{0, 2, 24'h001CF0, 8'h41, 0, 0, 0};
      vt[3]  = '{0, 1, 24'h000058, 8'h41, 1, 0, 0};
      vt[4]  = '{0, 1, 24'h00001C, 8'hE0, 1, 0, 0};
      vt[5]  = '{0, 1, 24'h000058, 8'hE0, 0, 0, 0};
      vt[6]  = '{0, 1, 24'h000012, 8'hE0, 0, 0, 0};
      vt[7]  = '{0, 1, 24'h00001C, 8'hE1, 0, 0, 0};
      vt[8]  = '{0, 2, 24'h0012F0, 8'hE1, 0, 0, 0};
      vt[9]  = '{0, 1, 24'h00001C, 8'hC1, 0, 0, 0};
      vt[10] = '{0, 1, 24'h000007, 8'hC1, 0, 1, 0};
      vt[11] = '{0, 2, 24'h0007F0, 8'hC1, 0, 0, 0};
      vt[12] = '{0, 1, 24'h00007E, 8'hC1, 0, 0, 1};
      vt[13] = '{0, 1, 24'h00007E, 8'hC1, 0, 0, 0};
      vt[14] = '{0, 2, 24'h0075E0, 8'h99, 0, 0, 0};
      vt[15] = '{0, 1, 24'h000016, 8'hB1, 0, 0, 0};
      vt[16] = '{0, 2, 24'h001612, 8'hA1, 0, 0, 0};
      vt[17] = '{0, 2, 24'h0012F0, 8'hA1, 0, 0, 0};
      vt[18] = '{1, 2, 24'h001CE1, 8'hC1, 0, 0, 0};
      vt[19] = '{1, 1, 24'h000005, 8'h41, 0, 0, 0};
      vt[20] = '{0, 2, 24'h001CF0, 8'h41, 0, 0, 0};
      vt[21] = '{0, 2, 24'h001CE0, 8'h41, 0, 0, 0};
      vt[22] = '{0, 1, 24'h00001C, 8'hC1, 0, 0, 0};

      kif.ps2_clk   = 1'b1;
      kif.ps2_data  = 1'b1;
      kif.key_clear = 1'b0;
      rst_n = 1'b0;
      wait_cyc(5);
      check("reset_state",
            {kif.key_reg, kif.key_rus, kif.key_rst, kif.key_pause, kif.frame_err}, 12'h000);
      rst_n = 1'b1;
      wait_cyc(5);

      // Vector table
      for (int i = 0; i < 23; i++) begin
         if (vt[i].clr) pulse_clear();
         for (int k = 0; k < vt[i].n; k++) send_byte(vt[i].bytes[8*k +: 8], 0, 0, 8'h00, 8'h00);
         check($sformatf("vec%0d", i),
               {kif.key_reg, kif.key_rus, kif.key_rst, kif.key_pause},
               {vt[i].exp_reg, vt[i].exp_rus, vt[i].exp_rst, vt[i].exp_pause});
      end
      check("no_err_table", err_seen, 0);

      // Parity error: pulse, latch untouched
      pulse_clear();
      err0 = err_seen;
      send_byte(8'h1C, 1, 0, 8'h00, 8'h00);
      check("parity_err_pulse", err_seen, err0 + 1);
      check("parity_err_latch", kif.key_reg, 8'h41);

      // Stalled frame after 5 data bits
      err0 = err_seen;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(i < 2 ? 1'b0 : 1'b1);
      waited = 0;
      while (err_seen == err0 && waited < 2500) begin
         wait_cyc(1);
         waited++;
      end
      check("timeout_pulse", err_seen, err0 + 1);
      check("timeout_delay_in_window", (waited >= 1800 && waited <= 2200), 1);
      send_byte(8'h1C, 0, 0, 8'h00, 8'h00);
      check("after_timeout", kif.key_reg, 8'hC1);

      // CPU clear on the very cycle a new key latches
      pulse_clear();
      send_byte(8'hE0, 0, 0, 8'h00, 8'h00);
      send_byte(8'h75, 0, 1, 8'h41, 8'h99);
      check("strobe_kept", kif.key_reg, 8'h99);

      // Reset in the middle of a frame
      send_byte(8'h58, 0, 0, 8'h00, 8'h00);
      send_byte(8'h7E, 0, 0, 8'h00, 8'h00);
      send_byte(8'h07, 0, 0, 8'h00, 8'h00);
      check("flags_before_reset", {kif.key_rus, kif.key_rst, kif.key_pause}, 3'b111);
      err0 = err_seen;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      rst_n = 1'b0;
      wait_cyc(3);
      check("mid_frame_reset",
            {kif.key_reg, kif.key_rus, kif.key_rst, kif.key_pause, kif.frame_err}, 12'h000);
      rst_n = 1'b1;
      wait_cyc(5);
      send_byte(8'h1C, 0, 0, 8'h00, 8'h00);
      check("frame_after_reset",
            {kif.key_reg, kif.key_rus, kif.key_rst, kif.key_pause}, {8'hC1, 3'b000});
      check("no_err_after_reset", err_seen, err0);

      // Random key stream against the reference model
      m_brk = 0; m_ext = 0; m_shift = 0; m_rus = 0; m_rst = 0; m_pause = 0;
      m_latch = 8'hC1;
      err0 = err_seen;
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            pulse_clear();
            m_latch[7] = 1'b0;
         end
         b = pool[$urandom_range(0, 19)];
         send_byte(b, 0, 0, 8'h00, 8'h00);
         model_byte(b);
         check($sformatf("rnd%0d_%h", i, b),
               {kif.key_reg, kif.key_rus, kif.key_rst, kif.key_pause},
               {m_latch, m_rus, m_rst, m_pause});
      end
      check("no_err_random", err_seen, err0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
